led_toggle: RTL and testbench

LED_TOGGLE -- requirements
Module: led_toggle

---
 rtl/led_toggle_pkg.sv | 12 +
 rtl/led_toggle_debounce.sv | 47 ++++
 rtl/led_toggle.sv | 55 +++++
 tb/tb_led_toggle.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/led_toggle_pkg.sv
// Shared constants and helpers for the led_toggle button/LED block.
package led_toggle_pkg;

   localparam int unsigned MAX_BTN                 = 8;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500000;

   // The counter only needs to reach DEBOUNCE_CYCLES-1, so clog2 bits suffice.
   function automatic int unsigned cnt_width(input int unsigned cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/led_toggle_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter, rising-edge press pulse.
module btn_debounce
   import led_toggle_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);

   localparam int unsigned   CW   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic          level_q;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         level   <= 1'b0;
         level_q <= 1'b0;
         cnt     <= '0;
      end else begin
         sync1   <= btn;
         sync2   <= sync1;
         level_q <= level;
         // Any agreement with the accepted level restarts qualification from zero.
         if (sync2 == level) begin
            cnt <= '0;
         end else if (cnt == TERM) begin
            level <= sync2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign press = level & ~level_q;

endmodule

// File: rtl/led_toggle.sv
// Debounced push-button LED toggler: reset synchronizer, per-button debouncers, LED registers.
module led_toggle
   import led_toggle_pkg::*;
#(
   parameter int unsigned N_BTN           = 2,
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn,
   output logic [N_BTN-1:0] led
);

   if (N_BTN < 1 || N_BTN > MAX_BTN) begin : g_bad_n_btn
      $error("led_toggle: N_BTN must be 1..%0d", MAX_BTN);
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
      $error("led_toggle: DEBOUNCE_CYCLES must be >= 2");
   end

   logic [1:0]       rst_pipe;
   logic             rst_sync_n;
   logic [N_BTN-1:0] press;

   // Assert asynchronously, release after two clocks.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_pipe <= '0;
      end else begin
         rst_pipe <= {rst_pipe[0], 1'b1};
      end
   end

   assign rst_sync_n = rst_pipe[1];

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .rst_n(rst_sync_n),
         .btn  (btn[i]),
         .press(press[i])
      );
   end

   always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
         led <= '0;
      end else begin
         led <= led ^ press;
      end
   end

endmodule

// File: tb/tb_led_toggle.sv
// Scoreboard bench for led_toggle with DEBOUNCE_CYCLES=4, N_BTN=2.
module tb_led_toggle;

   typedef struct {
      int unsigned cyc;
      logic [1:0]  val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [1:0] btn = 2'b11;
   logic [1:0] led;

   int unsigned cyc = 0;
   int          errors = 0;
   int          checks = 0;
   exp_t        q[$];
   logic [1:0]  prev = 2'b00;

   led_toggle #(
      .N_BTN          (2),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn),
      .led  (led)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // Monitor: every observed LED change must match the next expected entry.
   always @(negedge clk) begin
      if (led !== prev) begin
         prev = led;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change: led=%b at cycle %0d, required no change", led, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (led !== e.val) begin
               errors++;
               $display("FAIL led_value: got %b at cycle %0d, required %b", led, cyc, e.val);
            end
            checks++;
            if (cyc != e.cyc) begin
               errors++;
               $display("FAIL led_timing: change to %b at cycle %0d, required cycle %0d", led, cyc, e.cyc);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_change(input int unsigned at, input logic [1:0] v);
      exp_t e;
      e.cyc = at;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic check_led(input string name, input logic [1:0] req);
      checks++;
      if (led !== req) begin
         errors++;
         $display("FAIL %s: led=%b, required %b", name, led, req);
      end
   endtask

   initial begin
      // Async reset with buttons pressed, before any clock edge
      #1 rst_n = 1'b0;
      #1 check_led("async_reset", 2'b00);
      tick(1);
      btn = 2'b00;
      tick(3);
      rst_n = 1'b1;
      tick(5);

      // Both buttons pressed together, then released
      btn = 2'b11;
      expect_change(cyc + 7, 2'b11);
      tick(12);
      btn = 2'b00;
      tick(12);

      // Long press on btn[0], then btn[1] joins
      btn = 2'b01;
      expect_change(cyc + 7, 2'b10);
      tick(50);
      btn = 2'b11;
      expect_change(cyc + 7, 2'b00);
      tick(12);
      btn = 2'b00;
      tick(12);

      // Short glitches of 1, 2, 3 clocks: no toggle
      for (int w = 1; w <= 3; w++) begin
         btn = 2'b01;
         tick(w);
         btn = 2'b00;
         tick(5);
      end
      tick(8);

      // Bounce every clock for 20 clocks, then hold high
      for (int i = 0; i < 20; i++) begin
         btn = (i % 2 == 0) ? 2'b01 : 2'b00;
         tick(1);
      end
      btn = 2'b01;
      expect_change(cyc + 7, 2'b01);
      tick(15);
      btn = 2'b00;
      tick(12);

      // Reset in the middle of a btn[1] press; held press re-qualifies after release
      btn = 2'b10;
      tick(2);
      @(posedge clk);
      #2;
      expect_change(cyc, 2'b00);
      rst_n = 1'b0;
      #1 check_led("midpress_reset", 2'b00);
      tick(2);
      rst_n = 1'b1;
      expect_change(cyc + 9, 2'b10);
      tick(15);
      btn = 2'b00;
      tick(12);

      // A 4-clock pulse is just long enough to qualify
      btn = 2'b01;
      expect_change(cyc + 7, 2'b11);
      tick(4);
      btn = 2'b00;
      tick(15);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_changes: %0d expected changes pending, required 0", q.size());
      end
      check_led("final_led", 2'b11);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

endmodule
